conv_bias_fetcher: RTL and testbench
====================================

CONV_BIAS_FETCHER -- requirements
Module: conv_bias_fetcher

Interface
REQ-001 Parameter BIAS_W, default 32: signed bias word width.
REQ-002 Parameter DEPTH, default 32: bias storage entries; AW = clog2(DEPTH).
REQ-003 Parameter HCW, default 4: width of hold-cycle count.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_b  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a fetch sequence.
REQ-007 base_addr  input  AW  first bias address of the sequence.
REQ-008 num_bias  input  AW+1  bias count in the sequence, 1..DEPTH.
REQ-009 hold_cyc  input  HCW  cycles each bias is presented; 0 treated as 1.
REQ-010 stall  input  1  freezes sequencing while high.
REQ-011 wr_en  input  1  bias storage write strobe.
REQ-012 wr_addr  input  AW  write address.
REQ-013 wr_data  input  BIAS_W  write data.
REQ-014 bias_out  output  BIAS_W  current signed bias.
REQ-015 bias_valid  output  1  bias_out is valid for the consumer.
REQ-016 busy  output  1  sequence in progress.
REQ-017 done  output  1  one-cycle pulse at sequence end.
REQ-018 wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-019 Internal storage SHALL be a DEPTH x BIAS_W array with synchronous one-cycle read, no reset of contents.
REQ-020 FSM states SHALL be IDLE, FETCH, HOLD, DONE.
REQ-021 IDLE: start=1 at edge N latches base_addr, num_bias, hold_cyc; state -> FETCH; busy=1 from N+1.
REQ-022 FETCH: issue read of current address; next edge -> HOLD with bias_out loaded; bias_valid first high in cycle N+2.
REQ-023 Bias k (k=0..num_bias-1) SHALL equal mem[(base_addr+k) mod DEPTH]; address wraps from DEPTH-1 to 0.
REQ-024 HOLD: each bias SHALL remain on bias_out with bias_valid=1 for exactly max(hold_cyc,1) non-stalled cycles.
REQ-025 Next read SHALL be prefetched during the last hold cycle so consecutive biases present with no bubble; bias_valid stays continuously high across the whole sequence absent stall.
REQ-026 After the last hold cycle of the last bias: state -> DONE, bias_valid=0, done=1 for one cycle, busy=1 in that cycle; then IDLE, busy=0.
REQ-027 stall=1 SHALL freeze state, hold counter, address and bias_out; bias_valid keeps its value; prefetch read result is retained, not lost.
REQ-028 start while busy=1 SHALL be ignored; start coincident with done is ignored; start accepted the cycle after DONE.
REQ-029 wr_en in IDLE SHALL write wr_data to wr_addr; wr_en while busy=1 SHALL not write and SHALL pulse wr_err the next cycle.
REQ-030 Write and start in the same IDLE cycle: write completes first; sequence reads the new value.
REQ-031 num_bias=0 or >DEPTH SHALL be clamped to 1 and DEPTH respectively.
REQ-032 bias_out SHALL hold last value when bias_valid=0.

Reset
REQ-033 rst_b=0 SHALL immediately force state IDLE, bias_out=0, bias_valid=0, busy=0, done=0, wr_err=0, counters 0.
REQ-034 Reset mid-sequence SHALL abort without done pulse; storage contents SHALL be preserved.

Verification
REQ-035 Load mem[i]=i*3-40 for i=0..31; start base=0, num=4, hold=3 -> valid from cycle 2 for 12 cycles, values -40,-37,-34,-31 each 3 cycles, done at cycle 14.
REQ-036 base=30, num=4, hold=1 -> sequence mem[30],mem[31],mem[0],mem[1], no gaps, done one cycle after.
REQ-037 stall high 5 cycles mid-hold of bias 1 -> bias_out frozen, total valid cycles = 12+5, order unchanged.
REQ-038 wr_en while busy -> mem unchanged (read back later), wr_err pulses once; start while busy -> no restart.
REQ-039 rst_b low during bias 2 -> outputs 0 immediately, no done; new start afterwards runs correctly with old contents.
REQ-040 hold_cyc=0, num_bias=0 -> single bias presented one cycle, done next cycle.

Source files
------------

// File: rtl/conv_bias_fetcher.sv
// Bias sequencer: stores DEPTH signed bias words and replays a run of them.
// Ports: clk/rst_b, start+base_addr/num_bias/hold_cyc, stall, wr_*, bias_out/bias_valid/busy/done/wr_err.
module conv_bias_fetcher #(
  parameter int BIAS_W = 32,
  parameter int DEPTH  = 32,
  parameter int HCW    = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     start,
  input  logic [AW-1:0]            base_addr,
  input  logic [AW:0]              num_bias,
  input  logic [HCW-1:0]           hold_cyc,
  input  logic                     stall,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [BIAS_W-1:0]        wr_data,
  output logic signed [BIAS_W-1:0] bias_out,
  output logic                     bias_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [BIAS_W-1:0] mem [DEPTH];

  logic [AW-1:0]  addr;
  logic [AW:0]    left;
  logic [HCW-1:0] hlen;
  logic [HCW-1:0] hcnt;

  logic [AW:0]    num_c;
  logic [HCW-1:0] hold_c;
  logic [AW-1:0]  addr_nx;
  logic           is_idle;
  logic           is_fetch;
  logic           is_hold;
  logic           is_done;
  logic           last_hold;
  logic           rd;

  assign is_idle  = (state == IDLE);
  assign is_fetch = (state == FETCH);
  assign is_hold  = (state == HOLD);
  assign is_done  = (state == DONE);

  assign busy       = !is_idle;
  assign done       = is_done;
  assign bias_valid = is_hold;

  always_comb begin
    num_c = num_bias;
    if (num_bias == '0)
      num_c = (AW+1)'(1);
    else if (num_bias > (AW+1)'(DEPTH))
      num_c = (AW+1)'(DEPTH);
  end

  assign hold_c = (hold_cyc == '0) ? HCW'(1) : hold_cyc;

  assign addr_nx = (addr == AW'(DEPTH-1)) ? '0 : addr + AW'(1);

  assign last_hold = (hcnt == hlen - HCW'(1));

  // The next bias is read on the final hold cycle so it lands
  // on bias_out exactly when the current one retires.
  assign rd = !stall &&
              (is_fetch || (is_hold && last_hold && left != '0));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      is_idle:  if (start) nxt = FETCH;
      is_fetch: if (!stall) nxt = HOLD;
      is_hold:  if (!stall && last_hold && left == '0) nxt = DONE;
      is_done:  nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Contents survive reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (wr_en && is_idle)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr     <= '0;
      left     <= '0;
      hlen     <= '0;
      hcnt     <= '0;
      bias_out <= '0;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= wr_en && busy;
      if (is_idle && start) begin
        addr <= base_addr;
        left <= num_c;
        hlen <= hold_c;
        hcnt <= '0;
      end else if (rd) begin
        bias_out <= mem[addr];
        addr     <= addr_nx;
        left     <= left - (AW+1)'(1);
        hcnt     <= '0;
      end else if (is_hold && !stall) begin
        hcnt <= hcnt + HCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_bias_fetcher.sv
// Randomized bench for conv_bias_fetcher against a token-list model.
// Directed literal checks pin the model on the documented scenarios.
module tb_conv_bias_fetcher;

  logic               clk = 0;
  logic               rst_b;
  logic               start;
  logic [4:0]         base_addr;
  logic [5:0]         num_bias;
  logic [3:0]         hold_cyc;
  logic               stall;
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [31:0]        wr_data;
  logic signed [31:0] bias_out;
  logic               bias_valid;
  logic               busy;
  logic               done;
  logic               wr_err;

  conv_bias_fetcher dut (
    .clk(clk), .rst_b(rst_b), .start(start),
    .base_addr(base_addr), .num_bias(num_bias),
    .hold_cyc(hold_cyc), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bias_out(bias_out), .bias_valid(bias_valid),
    .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit b;
    bit d;
    logic signed [31:0] val;
  } tok_t;

  tok_t               tq[$];
  logic signed [31:0] m [32];
  logic signed [31:0] hold_val;
  bit                 exp_v, exp_b, exp_d, exp_we;
  logic signed [31:0] exp_val;
  int                 n_chk = 0;
  int                 n_pass = 0;
  bit                 chk_en = 0;

  task automatic chk(string nm, logic signed [31:0] got,
                     logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, got, exp, $time);
  endtask

  task automatic set_exp();
    if (tq.size() != 0) begin
      exp_v = tq[0].v; exp_b = tq[0].b;
      exp_d = tq[0].d; exp_val = tq[0].val;
    end else begin
      exp_v = 0; exp_b = 0; exp_d = 0; exp_val = hold_val;
    end
  endtask

  task automatic model_clear();
    tq.delete();
    hold_val = 0;
    exp_we = 0;
    set_exp();
  endtask

  // A sequence is a list of per-progress-cycle outputs:
  // one fetch slot, n*h bias slots, one done slot.
  task automatic build();
    int n, h, a;
    tok_t t;
    n = int'(num_bias);
    if (n == 0) n = 1;
    if (n > 32) n = 32;
    h = (hold_cyc == 0) ? 1 : int'(hold_cyc);
    t = '{0, 1, 0, hold_val};
    tq.push_back(t);
    for (int k = 0; k < n; k++) begin
      a = (int'(base_addr) + k) % 32;
      for (int j = 0; j < h; j++) begin
        t = '{1, 1, 0, m[a]};
        tq.push_back(t);
      end
      hold_val = m[a];
    end
    t = '{0, 1, 1, hold_val};
    tq.push_back(t);
  endtask

  task automatic model_edge();
    bit bb;
    if (!rst_b) begin
      model_clear();
      return;
    end
    bb = (tq.size() != 0);
    exp_we = wr_en && bb;
    if (bb) begin
      if (!(stall && !tq[0].d)) void'(tq.pop_front());
    end else begin
      if (wr_en) m[wr_addr] = wr_data;
      if (start) build();
    end
    set_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bias_valid", 32'(bias_valid), 32'(exp_v));
      chk("busy", 32'(busy), 32'(exp_b));
      chk("done", 32'(done), 32'(exp_d));
      chk("wr_err", 32'(wr_err), 32'(exp_we));
      chk("bias_out", bias_out, exp_val);
    end
  end

  task automatic go(int b, int n, int h);
    base_addr = 5'(b);
    num_bias  = 6'(n);
    hold_cyc  = 4'(h);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(int bound);
    int c;
    c = 0;
    while (tq.size() != 0 && c < bound) begin
      tick();
      c++;
    end
    if (tq.size() != 0) begin
      n_chk++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
      model_clear();
    end
  endtask

  int vcnt;

  initial begin
    rst_b = 0; start = 0; base_addr = 0; num_bias = 0;
    hold_cyc = 0; stall = 0; wr_en = 0; wr_addr = 0;
    wr_data = 0;
    model_clear();
    for (int i = 0; i < 32; i++) m[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst bias_out", bias_out, 0);
    chk("rst valid", 32'(bias_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst wr_err", 32'(wr_err), 0);
    rst_b = 1;
    chk_en = 1;

    for (int i = 0; i < 32; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i * 3 - 40);
      tick();
    end
    wr_en = 0;

    go(0, 4, 3);
    chk("s1 c1 busy", 32'(busy), 1);
    chk("s1 c1 valid", 32'(bias_valid), 0);
    for (int c = 2; c <= 15; c++) begin
      tick();
      if (c == 2) chk("s1 c2 bias", bias_out, -40);
      if (c == 2) chk("s1 c2 valid", 32'(bias_valid), 1);
      if (c == 5) chk("s1 c5 bias", bias_out, -37);
      if (c == 13) chk("s1 c13 bias", bias_out, -31);
      if (c == 14) chk("s1 c14 done", 32'(done), 1);
      if (c == 14) chk("s1 c14 valid", 32'(bias_valid), 0);
      if (c == 15) chk("s1 c15 busy", 32'(busy), 0);
    end

    go(30, 4, 1);
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (c == 2) chk("s2 c2 bias", bias_out, 50);
      if (c == 3) chk("s2 c3 bias", bias_out, 53);
      if (c == 4) chk("s2 c4 bias", bias_out, -40);
      if (c == 5) chk("s2 c5 bias", bias_out, -37);
      if (c == 6) chk("s2 c6 done", 32'(done), 1);
    end

    go(0, 4, 3);
    vcnt = 0;
    for (int c = 2; c <= 22; c++) begin
      tick();
      stall = (c >= 6 && c <= 10);
      if (bias_valid) vcnt++;
      if (c == 10) chk("s3 stalled bias", bias_out, -37);
      if (c == 19) chk("s3 c19 done", 32'(done), 1);
    end
    stall = 0;
    chk("s3 valid cycles", vcnt, 17);

    go(0, 2, 2);
    tick();
    wr_en = 1; wr_addr = 0; wr_data = 999; start = 1;
    base_addr = 7;
    tick();
    wr_en = 0; start = 0;
    chk("s4 wr_err", 32'(wr_err), 1);
    tick();
    chk("s4 wr_err once", 32'(wr_err), 0);
    wait_idle(50);
    tick();
    go(0, 1, 1);
    tick();
    chk("s4 readback", bias_out, -40);
    wait_idle(50);

    go(0, 4, 2);
    for (int c = 2; c <= 6; c++) tick();
    chk("s5 bias2", bias_out, -34);
    rst_b = 0;
    model_clear();
    #1;
    chk("s5 rst bias_out", bias_out, 0);
    chk("s5 rst valid", 32'(bias_valid), 0);
    chk("s5 rst busy", 32'(busy), 0);
    tick();
    rst_b = 1;
    tick();
    go(2, 2, 1);
    tick();
    chk("s5 rerun bias", bias_out, -34);
    wait_idle(50);

    go(5, 0, 0);
    tick();
    chk("s6 bias", bias_out, -25);
    chk("s6 valid", 32'(bias_valid), 1);
    tick();
    chk("s6 done", 32'(done), 1);
    wait_idle(50);

    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        wr_en = ($urandom_range(0, 1) == 1);
        wr_addr = 5'($urandom);
        wr_data = $urandom;
        tick();
      end
      wr_en = 0;
      go(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
         int'($urandom_range(0, 15)));
      for (int c = 0; c < 2000 && tq.size() != 0; c++) begin
        stall = (tq.size() != 0) && !tq[0].d &&
                ($urandom_range(0, 3) == 0);
        wr_en = ($urandom_range(0, 9) == 0);
        wr_addr = 5'($urandom);
        wr_data = $urandom;
        start = ($urandom_range(0, 9) == 0);
        base_addr = 5'($urandom);
        num_bias = 6'($urandom);
        tick();
      end
      stall = 0; wr_en = 0; start = 0;
      wait_idle(10);
    end

    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
